// File: rtl/raster_scan_ctrl.sv
// Triangle raster sequencer: clips the bounding box to the screen, walks it in
// row-major order one pixel per cycle and streams covered pixels downstream.
module raster_scan_ctrl #(
  parameter int COORD_W = 16,
  parameter int EDGE_W  = 2*COORD_W+3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  input  logic signed [COORD_W-1:0] tri_x0,
  input  logic signed [COORD_W-1:0] tri_y0,
  input  logic signed [COORD_W-1:0] tri_x1,
  input  logic signed [COORD_W-1:0] tri_y1,
  input  logic signed [COORD_W-1:0] tri_x2,
  input  logic signed [COORD_W-1:0] tri_y2,
  input  logic signed [COORD_W-1:0] width,
  input  logic signed [COORD_W-1:0] height,
  output logic                      frag_valid,
  input  logic                      frag_ready,
  output logic [COORD_W-1:0]        frag_x,
  output logic [COORD_W-1:0]        frag_y,
  output logic                      frag_last,
  output logic                      done,
  output logic [2*COORD_W-1:0]      frag_count,
  output logic [2:0]                state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a valid source holds its payload stable until that edge.

  // One extra bit so width-1 / height-1 and off-screen vertices never wrap.
  localparam int CW = COORD_W + 1;
  typedef logic signed [CW-1:0]     crd_t;
  typedef logic signed [EDGE_W-1:0] edg_t;

  localparam crd_t ZERO = crd_t'(0);
  localparam crd_t ONE  = crd_t'(1);
  localparam logic [2*COORD_W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  crd_t vx0, vy0, vx1, vy1, vx2, vy2, w_r, h_r;
  crd_t xmin, xmax, ymin, ymax, px, py;

  crd_t bx_min, bx_max, by_min, by_max;
  edg_t area, e0, e1, e2;
  logic empty_box, covered, at_end, adv, accept;

  function automatic crd_t min2(input crd_t a, input crd_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic crd_t max2(input crd_t a, input crd_t b);
    return (a > b) ? a : b;
  endfunction

  // (xj-xi)*(qy-yi) - (yj-yi)*(qx-xi), widened before any arithmetic.
  function automatic edg_t edge_fn(input crd_t xi, input crd_t yi,
                                   input crd_t xj, input crd_t yj,
                                   input crd_t qx, input crd_t qy);
    edg_t dx, dy, ox, oy;
    dx = edg_t'(xj) - edg_t'(xi);
    dy = edg_t'(yj) - edg_t'(yi);
    ox = edg_t'(qx) - edg_t'(xi);
    oy = edg_t'(qy) - edg_t'(yi);
    return dx * oy - dy * ox;
  endfunction

  assign state_dbg = state;
  assign accept    = (state == S_IDLE) && tri_valid && tri_ready;
  assign adv       = !frag_valid || frag_ready;
  assign at_end    = (px == xmax) && (py == ymax);

  always_comb begin
    bx_min    = max2(min2(min2(vx0, vx1), vx2), ZERO);
    bx_max    = min2(max2(max2(vx0, vx1), vx2), w_r - ONE);
    by_min    = max2(min2(min2(vy0, vy1), vy2), ZERO);
    by_max    = min2(max2(max2(vy0, vy1), vy2), h_r - ONE);
    area      = edge_fn(vx0, vy0, vx1, vy1, vx2, vy2);
    empty_box = (area == '0) || (bx_min > bx_max) || (by_min > by_max) ||
                (w_r <= ZERO) || (h_r <= ZERO);
  end

  // Both windings accepted; zero on an edge counts as inside.
  always_comb begin
    e0      = edge_fn(vx0, vy0, vx1, vy1, px, py);
    e1      = edge_fn(vx1, vy1, vx2, vy2, px, py);
    e2      = edge_fn(vx2, vy2, vx0, vy0, px, py);
    covered = (!e0[EDGE_W-1] && !e1[EDGE_W-1] && !e2[EDGE_W-1]) ||
              ((e0[EDGE_W-1] || e0 == '0) &&
               (e1[EDGE_W-1] || e1 == '0) &&
               (e2[EDGE_W-1] || e2 == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_SETUP;
      S_SETUP: next_state = empty_box ? S_DONE : S_SCAN;
      S_SCAN:  if (adv && at_end) next_state = S_DRAIN;
      S_DRAIN: if (adv) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Registered so that both read 0 while reset is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tri_ready <= 1'b0;
      done      <= 1'b0;
    end else begin
      tri_ready <= (next_state == S_IDLE);
      done      <= (next_state == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vx0 <= '0; vy0 <= '0; vx1 <= '0; vy1 <= '0;
      vx2 <= '0; vy2 <= '0; w_r <= '0; h_r <= '0;
    end else if (accept) begin
      vx0 <= crd_t'(tri_x0); vy0 <= crd_t'(tri_y0);
      vx1 <= crd_t'(tri_x1); vy1 <= crd_t'(tri_y1);
      vx2 <= crd_t'(tri_x2); vy2 <= crd_t'(tri_y2);
      w_r <= crd_t'(width);  h_r <= crd_t'(height);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
      px   <= '0; py   <= '0;
    end else if (state == S_SETUP) begin
      xmin <= bx_min; xmax <= bx_max;
      ymin <= by_min; ymax <= by_max;
      px   <= bx_min; py   <= by_min;
    end else if (state == S_SCAN && adv) begin
      if (px == xmax) begin
        px <= xmin;
        py <= py + ONE;
      end else begin
        px <= px + ONE;
      end
    end
  end

  // frag_last only flags a fragment at (xmax,ymax); when the final covered
  // pixel lies elsewhere in the box, done alone marks the end of the triangle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frag_valid <= 1'b0;
      frag_x     <= '0;
      frag_y     <= '0;
      frag_last  <= 1'b0;
      frag_count <= '0;
    end else if (accept) begin
      frag_last  <= 1'b0;
      frag_count <= '0;
    end else if (state == S_SCAN && adv) begin
      if (covered) begin
        frag_valid <= 1'b1;
        frag_x     <= px[COORD_W-1:0];
        frag_y     <= py[COORD_W-1:0];
        frag_last  <= at_end;
        frag_count <= frag_count + CNT_ONE;
      end else begin
        frag_valid <= 1'b0;
      end
    end else if (frag_valid && frag_ready) begin
      frag_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Directed bench for raster_scan_ctrl: a table of triangles with hand-derived
// fragment sets and latencies, plus backpressure and mid-scan reset sequences.
module tb_raster_scan_ctrl;

  localparam int CW = 16;

  typedef enum int {K_NONE, K_DIAG, K_FULL4, K_LOWER} kind_t;

  typedef struct {
    logic signed [CW-1:0] x0, y0, x1, y1, x2, y2, w, h;
    kind_t kind;
    int    exp_cnt;
    int    exp_lat;   // cycle index of done, accept cycle = 0, frag_ready held 1
    logic  exp_last;  // frag_last on the final fragment
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 tri_valid;
  logic                 tri_ready;
  logic signed [CW-1:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
  logic signed [CW-1:0] width, height;
  logic                 frag_valid;
  logic                 frag_ready;
  logic [CW-1:0]        frag_x, frag_y;
  logic                 frag_last;
  logic                 done;
  logic [2*CW-1:0]      frag_count;
  logic [2:0]           state_dbg;

  logic [2*CW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  localparam int NV = 7;
  vec_t vt[NV];

  raster_scan_ctrl #(.COORD_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_x0(tri_x0), .tri_y0(tri_y0), .tri_x1(tri_x1), .tri_y1(tri_y1),
    .tri_x2(tri_x2), .tri_y2(tri_y2), .width(width), .height(height),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_last(frag_last),
    .done(done), .frag_count(frag_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input int w, input int h,
                              input kind_t k, input int cnt, input int lat, input logic last);
    vec_t v;
    v.x0 = CW'(x0); v.y0 = CW'(y0); v.x1 = CW'(x1); v.y1 = CW'(y1);
    v.x2 = CW'(x2); v.y2 = CW'(y2); v.w = CW'(w); v.h = CW'(h);
    v.kind = k; v.exp_cnt = cnt; v.exp_lat = lat; v.exp_last = last;
    return v;
  endfunction

  // Expected covered sets, row-major, written from the triangle geometry.
  task automatic fill_expected(input kind_t k);
    exp_q.delete();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        if (k == K_DIAG && x + y <= 4) exp_q.push_back({16'(y), 16'(x)});
        if (k == K_FULL4 && x < 4 && y < 4) exp_q.push_back({16'(y), 16'(x)});
        if (k == K_LOWER && x < 4 && y < 4 && y <= x) exp_q.push_back({16'(y), 16'(x)});
      end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tri_ready"}, tri_ready, 0);
    chk({tag, "_frag_valid"}, frag_valid, 0);
    chk({tag, "_frag_x"}, frag_x, 0);
    chk({tag, "_frag_y"}, frag_y, 0);
    chk({tag, "_frag_last"}, frag_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_frag_count"}, frag_count, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // Waits at a negedge until the DUT can take a triangle, then offers v.
  task automatic offer(input vec_t v);
    int guard = 0;
    @(negedge clk);
    while (!tri_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("tri_ready_seen", tri_ready, 1);
    tri_x0 = v.x0; tri_y0 = v.y0; tri_x1 = v.x1; tri_y1 = v.y1;
    tri_x2 = v.x2; tri_y2 = v.y2; width = v.w; height = v.h;
    tri_valid  = 1'b1;
    frag_ready = 1'b1;
  endtask

  task automatic run_tri(input vec_t v, input int stall_idx, input int stall_len);
    int  got = 0, dones = 0, done_cyc = -1, k = 0, stall_left = stall_len;
    bit  stalled = 0;
    logic [2*CW-1:0] e;
    fill_expected(v.kind);
    offer(v);
    while (k < 200 && !(dones > 0 && k > done_cyc + 2)) begin
      @(negedge clk);
      k++;
      tri_valid = 1'b0;
      if (k == 1) begin
        chk("setup_tri_ready", tri_ready, 0);
        chk("count_cleared", frag_count, 0);
      end
      if (stall_left > 0 && got == stall_idx && (frag_valid || stalled)) begin
        stalled = 1;
        chk("stall_valid_held", frag_valid, 1);
        if (exp_q.size() > 0) chk("stall_xy_held", {frag_y, frag_x}, exp_q[0]);
        frag_ready = 1'b0;
        stall_left--;
      end else begin
        frag_ready = 1'b1;
      end
      if (frag_valid && frag_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_frag", {frag_y, frag_x}, '1);
        end else begin
          e = exp_q.pop_front();
          chk("frag_xy", {frag_y, frag_x}, e);
          chk("frag_last", frag_last, (exp_q.size() == 0) ? v.exp_last : 1'b0);
        end
        got++;
      end
      if (done) begin
        dones++;
        done_cyc = k;
      end
    end
    chk("done_once", dones, 1);
    chk("done_latency", done_cyc, v.exp_lat + stall_len);
    chk("frag_total", got, v.exp_cnt);
    chk("frags_missing", exp_q.size(), 0);
    chk("frag_count", frag_count, v.exp_cnt);
  endtask

  initial begin
    int got, k;
    reset_n = 1'b0; tri_valid = 1'b0; frag_ready = 1'b1;
    tri_x0 = '0; tri_y0 = '0; tri_x1 = '0; tri_y1 = '0;
    tri_x2 = '0; tri_y2 = '0; width = '0; height = '0;
    #1 check_reset("por");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Bbox 5x5 -> 25 scan cycles; 4x4 -> 16; empty work finishes at index 2.
    vt[0] = mk(0, 0, 4, 0, 0, 4, 8, 8, K_DIAG, 15, 28, 1'b0);
    vt[1] = mk(0, 0, 0, 4, 4, 0, 8, 8, K_DIAG, 15, 28, 1'b0);
    vt[2] = mk(0, 0, 2, 2, 4, 4, 8, 8, K_NONE, 0, 2, 1'b0);
    vt[3] = mk(-2, -2, 10, -2, -2, 10, 4, 4, K_FULL4, 16, 19, 1'b1);
    vt[4] = mk(20, 20, 30, 20, 20, 30, 8, 8, K_NONE, 0, 2, 1'b0);
    vt[5] = mk(0, 0, 3, 0, 3, 3, 8, 8, K_LOWER, 10, 19, 1'b1);
    vt[6] = mk(0, 0, 4, 0, 0, 4, 0, 8, K_NONE, 0, 2, 1'b0);

    for (int i = 0; i < NV; i++) run_tri(vt[i], -1, 0);

    // Consumer stalls 5 cycles while (2,0) is presented.
    run_tri(vt[0], 2, 5);

    // Reset during the scan, after four fragments have been taken.
    fill_expected(K_DIAG);
    offer(vt[0]);
    got = 0; k = 0;
    while (got < 4 && k < 60) begin
      @(negedge clk);
      tri_valid = 1'b0;
      k++;
      if (frag_valid && frag_ready) got++;
    end
    chk("abort_four_frags", got, 4);
    @(negedge clk);
    chk("abort_in_scan", state_dbg, 2);
    reset_n = 1'b0;
    #1 check_reset("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_no_frag", frag_valid, 0);
    end
    reset_n = 1'b1;
    run_tri(vt[0], -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
